time_decoder: RTL and testbench
===============================

# time_decoder

Receive-side stage for the time-encoded link: it measures the width of each high pulse on `tin` produced by the time encoder and recovers the DATA_W-bit symbol. A `start` strobe opens a fixed measurement window, and the recovered code is presented with a one-cycle `valid`. It sits directly downstream of the encoder; the encoder's time unit equals UNIT_CYC cycles of `clk`.

## Interface
- `DATA_W`, 2: symbol width; max code `CMAX = 2**DATA_W-1`.
- `UNIT_CYC`, 4: `clk` cycles per encoder time unit; even, ≥2.
- `WINDOW_CYC`, 20: window length in cycles after `start`; must be ≥ `(CMAX+1)*UNIT_CYC`.
- `CNT_W`, `$clog2(WINDOW_CYC+1)`: width counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: synchronous one-cycle strobe; marks the symbol start, aligned to the encoder's `start`.
- `tin` in 1: time-encoded pulse from the encoder.
- `dout` out DATA_W: recovered code; holds its value until the next result.
- `valid` out 1: one-cycle strobe qualifying `dout` and `err`.
- `err` out 1: the result carried a fault; meaningful only with `valid`.

## Operation
- **FSM states:** IDLE, WAIT, MEAS, DONE.
  - **IDLE:** `tin` is ignored. On `start`: clear `win_cnt` and `width`, go to WAIT.
  - **WAIT:** `win_cnt++` every cycle.
    - `tin` sampled high: `width=1`, go to MEAS.
    - No pulse and `win_cnt==WINDOW_CYC-1`: result code 0, `err=0`, go to DONE.
  - **MEAS:** `win_cnt++` every cycle.
    - `tin` high: `width++`, saturating at `2**CNT_W-1`.
    - `tin` sampled low: quantize `width`, go to DONE.
    - Window expires while `tin` is still high: code=CMAX, `err=1`, go to DONE.
  - **DONE:** `valid=1` for this cycle only, `dout`/`err` updated; go to IDLE.
- **Quantization:**
  - `q = (width + UNIT_CYC/2) / UNIT_CYC`, computed at `CNT_W+1` bits so there is no overflow.
  - `q==0` (glitch shorter than half a unit): code 0, `err=1`.
  - `q>CMAX`: code CMAX, `err=1`.
  - Otherwise: code = `q[DATA_W-1:0]`, `err=0`.
- **Busy start:** `start` in WAIT/MEAS/DONE is ignored for timing, but sets a sticky `busy_hit`. `busy_hit` ORs into the `err` of the current result and is cleared in DONE.
- **`tin` already high in IDLE:** not counted. If `tin` is high on the first WAIT cycle, that counts as the rising edge.
- **`tin` never low between symbols:** covered by the window-expiry rule.

## Timing
- **Reset values:** state=IDLE; `dout=0`, `valid=0`, `err=0`; `win_cnt=0`, `width=0`, `busy_hit=0`. Reset is asynchronous and may assert mid-symbol. After release, the FSM waits for a fresh `start`, and a partial pulse is discarded.
- **`start` timing:** `start` is sampled on edge N. WAIT is active from cycle N+1. `tin` is first sampled on edge N+1.
- **Pulse latency:** `tin` is first sampled low on edge M, so `valid` is high in cycle M+1 (registered). The same applies from the window-expiry edge.
- **No-pulse result:** `valid` is asserted `WINDOW_CYC+1` cycles after the `start` edge.
- **Back-to-back symbols:** minimum `start` spacing is `WINDOW_CYC+2` cycles.

## Configuration
- **`TIME_DECODER_SYNC_EN` defined:** `tin` passes through a 2-flop synchronizer before the FSM. All `tin`-referenced latencies grow by 2 cycles. The window opens 2 cycles later too (the `start` strobe is delayed 2 stages), so widths are unchanged.
- **Undefined:** `tin` is used directly and must be synchronous to `clk`.

## Structure
- **Package `time_code_pkg`:** FSM state enum (`TD_IDLE`, `TD_WAIT`, `TD_MEAS`, `TD_DONE`) and default `DATA_W`/`UNIT_CYC` constants, shared with the encoder bench.
- **Sub-module `pulse_quantizer`:** combinational; inputs `width`; outputs `code` and `err`, implementing the rounding and saturation rules. Instanced once.

## Test plan
All scenarios use the defaults: UNIT_CYC=4, WINDOW_CYC=20, DATA_W=2.
- `start`, then `tin` high 8 cycles → `dout=2`, `err=0`, `valid` 1 cycle after the first low sample.
- `start` with `tin` held low → `dout=0`, `err=0`, `valid` at `start`+21.
- Pulse widths 1, 5, 6, 12 → codes 0/`err=1`, 1, 2, 3 respectively; all `err=0` except width 1.
- `tin` high from WAIT through window end → `dout=3`, `err=1`.
- Second `start` mid-MEAS on a 4-cycle pulse → single `valid`, `dout=1`, `err=1`.
- `rst_n` low for 1 cycle mid-MEAS → all outputs 0, no `valid`; the next `start` + 12-cycle pulse gives `dout=3`.

Source files
------------

// File: rtl/time_code_pkg.sv
// Shared definitions for the time-encoded link: decoder FSM states and default link constants.
package time_code_pkg;

  typedef enum logic [1:0] {
    TD_IDLE,
    TD_WAIT,
    TD_MEAS,
    TD_DONE
  } td_state_e;

  localparam int unsigned TD_DATA_W   = 2;
  localparam int unsigned TD_UNIT_CYC = 4;

endpackage

// File: rtl/time_decoder_if.sv
// Symbol-level signals between the time-encoded link front end and the decoder.
interface time_decoder_if
  import time_code_pkg::*;
#(
  parameter int unsigned DATA_W = TD_DATA_W
);
  logic              start;
  logic              tin;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic              err;

  modport master (
    output start,
    output tin,
    input  dout,
    input  valid,
    input  err
  );

  modport slave (
    input  start,
    input  tin,
    output dout,
    output valid,
    output err
  );
endinterface

// File: rtl/pulse_quantizer.sv
// Rounds a measured pulse width to the nearest encoder time unit and saturates to the code range.
module pulse_quantizer #(
  parameter int unsigned DATA_W   = 2,
  parameter int unsigned UNIT_CYC = 4,
  parameter int unsigned CNT_W    = 5
) (
  input  logic [CNT_W-1:0]  width,
  output logic [DATA_W-1:0] code,
  output logic              err
);
  localparam int unsigned CMAX = 2 ** DATA_W - 1;

  // One extra bit keeps width + UNIT_CYC/2 from wrapping.
  logic [CNT_W:0] q;

  // Round to nearest unit, then flag glitches and over-range pulses.
  always_comb begin
    q    = ({1'b0, width} + (CNT_W + 1)'(UNIT_CYC / 2)) / (CNT_W + 1)'(UNIT_CYC);
    code = '0;
    err  = 1'b0;
    if (q == '0) begin
      err = 1'b1;
    end else if (q > (CNT_W + 1)'(CMAX)) begin
      code = DATA_W'(CMAX);
      err  = 1'b1;
    end else begin
      code = q[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/time_decoder.sv
// Measures each tin high pulse inside a window opened by start and recovers the symbol code.
// Optional TIME_DECODER_SYNC_EN: 2-flop tin synchronizer, with start delayed to match.
module time_decoder
  import time_code_pkg::*;
#(
  parameter int unsigned DATA_W     = TD_DATA_W,
  parameter int unsigned UNIT_CYC   = TD_UNIT_CYC,
  parameter int unsigned WINDOW_CYC = 20,
  parameter int unsigned CNT_W      = $clog2(WINDOW_CYC + 1)
) (
  input logic           clk,
  input logic           rst_n,
  time_decoder_if.slave bus
);
  localparam int unsigned CMAX = 2 ** DATA_W - 1;
  localparam logic [CNT_W-1:0] WidthMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WinLast  = CNT_W'(WINDOW_CYC - 1);

  logic tin_s;
  logic start_s;

`ifdef TIME_DECODER_SYNC_EN
  logic [1:0] tin_sync_q;
  logic [1:0] start_dly_q;

  // Synchronize tin; delay start equally so the window stays aligned with the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tin_sync_q  <= '0;
      start_dly_q <= '0;
    end else begin
      tin_sync_q  <= {tin_sync_q[0], bus.tin};
      start_dly_q <= {start_dly_q[0], bus.start};
    end
  end

  assign tin_s   = tin_sync_q[1];
  assign start_s = start_dly_q[1];
`else
  assign tin_s   = bus.tin;
  assign start_s = bus.start;
`endif

  td_state_e         state_q, state_d;
  logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]  width_q, width_d;
  logic              busy_hit_q, busy_hit_d;
  logic [DATA_W-1:0] res_code_q, res_code_d;
  logic              res_err_q, res_err_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] q_code;
  logic              q_err;
  logic              win_last;

  pulse_quantizer #(
    .DATA_W  (DATA_W),
    .UNIT_CYC(UNIT_CYC),
    .CNT_W   (CNT_W)
  ) u_quant (
    .width(width_q),
    .code (q_code),
    .err  (q_err)
  );

  assign win_last = (win_cnt_q >= WinLast);

  // Next-state, counters and result capture.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    width_d    = width_q;
    busy_hit_d = busy_hit_q;
    res_code_d = res_code_q;
    res_err_d  = res_err_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      TD_IDLE: begin
        if (start_s) begin
          win_cnt_d = '0;
          width_d   = '0;
          state_d   = TD_WAIT;
        end
      end
      TD_WAIT: begin
        win_cnt_d  = win_cnt_q + CNT_W'(1);
        busy_hit_d = busy_hit_q | start_s;
        if (tin_s && win_last) begin
          // Rising edge on the very last window cycle cannot be measured.
          res_code_d = DATA_W'(CMAX);
          res_err_d  = 1'b1;
          state_d    = TD_DONE;
        end else if (tin_s) begin
          width_d = CNT_W'(1);
          state_d = TD_MEAS;
        end else if (win_last) begin
          res_code_d = '0;
          res_err_d  = 1'b0;
          state_d    = TD_DONE;
        end
      end
      TD_MEAS: begin
        win_cnt_d  = win_cnt_q + CNT_W'(1);
        busy_hit_d = busy_hit_q | start_s;
        if (!tin_s) begin
          res_code_d = q_code;
          res_err_d  = q_err;
          state_d    = TD_DONE;
        end else if (win_last) begin
          res_code_d = DATA_W'(CMAX);
          res_err_d  = 1'b1;
          state_d    = TD_DONE;
        end else if (width_q != WidthMax) begin
          width_d = width_q + CNT_W'(1);
        end
      end
      TD_DONE: begin
        valid_d    = 1'b1;
        dout_d     = res_code_q;
        err_d      = res_err_q | busy_hit_q | start_s;
        busy_hit_d = 1'b0;
        state_d    = TD_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any partial measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TD_IDLE;
      win_cnt_q  <= '0;
      width_q    <= '0;
      busy_hit_q <= 1'b0;
      res_code_q <= '0;
      res_err_q  <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      width_q    <= width_d;
      busy_hit_q <= busy_hit_d;
      res_code_q <= res_code_d;
      res_err_q  <= res_err_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.dout  = dout_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_time_decoder.sv
// Directed bench for time_decoder: expected results are queued when a symbol is driven and
// checked (code, err, arrival cycle) when valid appears.
module tb_time_decoder;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  typedef struct {
    logic [1:0] code;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  time_decoder_if #(.DATA_W(2)) bus ();

  time_decoder #(
    .DATA_W    (2),
    .UNIT_CYC  (4),
    .WINDOW_CYC(20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every valid must match the oldest queued expectation, including its arrival cycle.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      exp_t e;
      chk("valid_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dout", int'(bus.dout), int'(e.code));
        chk("err", int'(bus.err), int'(e.err));
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  // Start strobe sampled on edge n, then tin high for w sampled edges (0 = no pulse).
  task automatic symbol(input int w, input logic [1:0] code, input logic err);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    n = cyc + 1;
    e.code = code;
    e.err  = err;
    e.cyc  = (w == 0 || w >= 20) ? n + 21 : n + w + 2;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    if (w > 0) begin
      bus.tin = 1'b1;
      repeat ((w > 22) ? 22 : w) @(negedge clk);
      bus.tin = 1'b0;
    end
    while (cyc < n + 24) @(negedge clk);
  endtask

  initial begin
    int   n;
    int   guard;
    exp_t e;
    n_cmp     = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.tin   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_dout", int'(bus.dout), 0);
    chk("reset_err", int'(bus.err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    symbol(8, 2'd2, 1'b0);
    symbol(0, 2'd0, 1'b0);
    symbol(1, 2'd0, 1'b1);
    symbol(5, 2'd1, 1'b0);
    symbol(6, 2'd2, 1'b0);
    symbol(12, 2'd3, 1'b0);
    symbol(99, 2'd3, 1'b1);

    // Second start while measuring a 4-cycle pulse.
    @(negedge clk);
    bus.start = 1'b1;
    n = cyc + 1;
    e.code = 2'd1;
    e.err  = 1'b1;
    e.cyc  = n + 6;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.tin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.tin = 1'b0;
    while (cyc < n + 24) @(negedge clk);

    // Reset mid-measurement: outputs clear and the partial pulse yields no result.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.tin   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", int'(bus.valid), 0);
    chk("midreset_dout", int'(bus.dout), 0);
    chk("midreset_err", int'(bus.err), 0);
    @(negedge clk);
    bus.tin = 1'b0;
    rst_n   = 1'b1;
    repeat (25) @(negedge clk);
    symbol(12, 2'd3, 1'b0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
